// File: rtl/fft_frame_sequencer.sv
// Drains one buffered frame from the sample FIFO into the FFT sink through a 2-entry skid buffer.
// Optional FFT_SEQ_STATS_EN adds a frame counter and a sticky underrun flag.
module fft_frame_sequencer #(
  parameter int FRAME_LEN = 8192,
  parameter int USEDW_W   = 14,
  parameter int SAMPLE_W  = 32,
  parameter int DATA_W    = 16
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                enable,
  input  logic [USEDW_W-1:0]  rdusedw,
  input  logic                rdempty,
  output logic                rdreq,
  input  logic [SAMPLE_W-1:0] q,
  input  logic                sink_ready,
  output logic                sink_valid,
  output logic                sink_sop,
  output logic                sink_eop,
  output logic [DATA_W-1:0]   sink_real,
  output logic [DATA_W-1:0]   sink_imag,
  output logic [1:0]          sink_error,
  output logic                busy,
  output logic                frame_done
`ifdef FFT_SEQ_STATS_EN
  ,
  output logic [15:0]         frame_count,
  output logic                underrun
`endif
);

  localparam int CNT_W = $clog2(FRAME_LEN) + 1;
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [USEDW_W:0]   FILL_LVL = (USEDW_W + 1)'(FRAME_LEN);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic               inflight_q;
  logic [1:0]         occ_q, occ_d;
  logic [DATA_W-1:0]  skid0_q, skid0_d;
  logic [DATA_W-1:0]  skid1_q, skid1_d;
  logic               frame_done_q, frame_done_d;
  logic               push, pop, eop_accept;
  logic [DATA_W-1:0]  q_data;

  assign q_data     = q[SAMPLE_W-1 -: DATA_W];
  assign push       = inflight_q;
  assign sink_valid = (occ_q != 2'd0);
  assign pop        = sink_valid && sink_ready;
  assign sink_sop   = sink_valid && (out_cnt_q == '0);
  assign sink_eop   = sink_valid && (out_cnt_q == CNT_LAST);
  assign eop_accept = pop && (out_cnt_q == CNT_LAST);
  assign sink_real  = skid0_q;
  assign sink_imag  = '0;
  assign sink_error = 2'b00;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = frame_done_q;

  // Credit counts held entries even if one pops this cycle, so rdreq never depends on
  // sink_ready; the price is a sustained rate of two beats per three cycles.
  assign rdreq = (state_q == S_STREAM) && (rd_cnt_q < CNT_FULL) && !rdempty &&
                 (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd2);

  always_comb begin
    state_d      = state_q;
    rd_cnt_d     = rd_cnt_q;
    out_cnt_d    = out_cnt_q;
    frame_done_d = eop_accept;
    if (rdreq) rd_cnt_d = rd_cnt_q + 1'b1;
    if (pop)   out_cnt_d = out_cnt_q + 1'b1;
    case (state_q)
      S_IDLE: if (enable) state_d = S_FILL;
      S_FILL: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (({1'b0, rdusedw} >= FILL_LVL) && !rdempty) begin
          state_d   = S_STREAM;
          rd_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      S_STREAM: if (eop_accept) state_d = enable ? S_FILL : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    occ_d   = occ_q;
    skid0_d = skid0_q;
    skid1_d = skid1_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) skid0_d = q_data;
        else               skid1_d = q_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        skid0_d = skid1_q;
        occ_d   = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          skid0_d = q_data;
        end else begin
          skid0_d = skid1_q;
          skid1_d = q_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      rd_cnt_q     <= '0;
      out_cnt_q    <= '0;
      inflight_q   <= 1'b0;
      occ_q        <= 2'd0;
      skid0_q      <= '0;
      skid1_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_cnt_q     <= rd_cnt_d;
      out_cnt_q    <= out_cnt_d;
      inflight_q   <= rdreq;
      occ_q        <= occ_d;
      skid0_q      <= skid0_d;
      skid1_q      <= skid1_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef FFT_SEQ_STATS_EN
  logic [15:0] frame_count_q;
  logic        underrun_q;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      frame_count_q <= 16'd0;
      underrun_q    <= 1'b0;
    end else begin
      if (frame_done_q) frame_count_q <= frame_count_q + 16'd1;
      if ((state_q == S_STREAM) && (rd_cnt_q < CNT_FULL) && rdempty) underrun_q <= 1'b1;
    end
  end

  assign frame_count = frame_count_q;
  assign underrun    = underrun_q;
`endif

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Randomised bench for fft_frame_sequencer: a FIFO model feeds random samples and a stream
// monitor checks order, framing, stall hold and read-credit rules against plain counts.
module tb_fft_frame_sequencer;
  localparam int FL = 256;
  localparam int UW = 10;

  logic          CLOCK_50 = 1'b0;
  logic          resetn = 1'b0;
  logic          enable = 1'b0;
  logic [UW-1:0] rdusedw;
  logic          rdempty;
  logic          rdreq;
  logic [31:0]   q = '0;
  logic          sink_ready = 1'b0;
  logic          sink_valid, sink_sop, sink_eop;
  logic [15:0]   sink_real, sink_imag;
  logic [1:0]    sink_error;
  logic          busy, frame_done;
`ifdef FFT_SEQ_STATS_EN
  logic [15:0]   frame_count;
  logic          underrun;
`endif

  fft_frame_sequencer #(.FRAME_LEN(FL), .USEDW_W(UW), .SAMPLE_W(32), .DATA_W(16)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .enable(enable), .rdusedw(rdusedw),
    .rdempty(rdempty), .rdreq(rdreq), .q(q), .sink_ready(sink_ready),
    .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_real(sink_real), .sink_imag(sink_imag), .sink_error(sink_error),
    .busy(busy), .frame_done(frame_done)
`ifdef FFT_SEQ_STATS_EN
    , .frame_count(frame_count), .underrun(underrun)
`endif
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // FIFO model: legacy read, data appears the cycle after rdreq.
  logic [31:0] mem [0:4095];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        flush = 1'b0;
  logic        force_empty = 1'b0;

  assign rdusedw = UW'(wr_ptr - rd_ptr);
  assign rdempty = (wr_ptr == rd_ptr) || force_empty;

  always @(posedge CLOCK_50) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (rdreq) begin
      q      <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Stream monitor: expected stream is simply the FIFO contents in push order.
  int          reads_total = 0, beats_total = 0, done_cnt = 0, beat_pos = 0, exp_ptr = 0;
  int          mon_bad = 0;
  logic        prev_stall = 1'b0, prev_eop_acc = 1'b0, prev_sop = 1'b0, prev_eop = 1'b0;
  logic [15:0] prev_real = '0;
  logic [31:0] exp_word;
  logic        acc, eop_acc;

  always @(negedge CLOCK_50) begin
    if (!resetn) begin
      reads_total = 0; beats_total = 0; done_cnt = 0; beat_pos = 0;
      prev_stall = 1'b0; prev_eop_acc = 1'b0; exp_ptr = wr_ptr;
    end else begin
      if (frame_done !== prev_eop_acc) begin
        mon_bad++;
        $display("monitor: frame_done got %b exp %b at %0t", frame_done, prev_eop_acc, $time);
      end
      if (frame_done === 1'b1) done_cnt++;
      if (prev_stall && (sink_valid !== 1'b1 || sink_real !== prev_real ||
                         sink_sop !== prev_sop || sink_eop !== prev_eop)) begin
        mon_bad++;
        $display("monitor: stalled beat changed at %0t", $time);
      end
      if (rdreq === 1'b1) begin
        if (rdempty || (reads_total - beats_total) >= 2 || reads_total >= FL * (beats_total / FL + 1)) begin
          mon_bad++;
          $display("monitor: illegal rdreq reads=%0d beats=%0d empty=%b at %0t",
                   reads_total, beats_total, rdempty, $time);
        end
        reads_total++;
      end
      acc     = sink_valid && sink_ready;
      eop_acc = 1'b0;
      if (acc) begin
        exp_word = mem[exp_ptr];
        if (sink_real !== exp_word[31:16] || sink_sop !== (beat_pos == 0) ||
            sink_eop !== (beat_pos == FL - 1)) begin
          mon_bad++;
          $display("monitor: beat %0d got %h sop %b eop %b exp %h at %0t",
                   beat_pos, sink_real, sink_sop, sink_eop, exp_word[31:16], $time);
        end
        eop_acc  = (beat_pos == FL - 1);
        exp_ptr++;
        beats_total++;
        beat_pos = (beat_pos + 1) % FL;
      end else if (sink_valid !== 1'b1 && (sink_sop !== 1'b0 || sink_eop !== 1'b0)) begin
        mon_bad++;
        $display("monitor: framing without valid at %0t", $time);
      end
      if (sink_imag !== 16'h0 || sink_error !== 2'b00) begin
        mon_bad++;
        $display("monitor: constant outputs changed at %0t", $time);
      end
      prev_eop_acc = eop_acc;
      prev_stall   = sink_valid && !sink_ready;
      prev_real    = sink_real;
      prev_sop     = sink_sop;
      prev_eop     = sink_eop;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = $urandom;
      wr_ptr++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b0; sink_ready = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({rdreq, sink_valid, sink_sop, sink_eop, busy, frame_done} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b exp 000000", {rdreq, sink_valid, sink_sop, sink_eop, busy, frame_done});
    end
    vectors++;
    if (sink_real !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_real got %h exp 0000", sink_real);
    end
    resetn = 1'b1;
    repeat (2) tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_busy got %b exp 0", busy);
    end
`ifdef FFT_SEQ_STATS_EN
    vectors++;
    if (frame_count !== 16'd0 || underrun !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_stats got count %0d underrun %b exp 0 0", frame_count, underrun);
    end
`endif
  endtask

  task automatic test_full_frame();
    int d0, b0, r0, bad0, first_rd, first_v, rd_after;
    d0 = done_cnt; b0 = beats_total; r0 = reads_total; bad0 = mon_bad;
    first_rd = -1; first_v = -1; rd_after = 0;
    enable = 1'b1; sink_ready = 1'b1;
    tick();
    push(FL);
    for (int c = 0; c < 4 * FL; c++) begin
      tick();
      if (rdreq && first_rd < 0) first_rd = c;
      if (sink_valid && first_v < 0) first_v = c;
      if (done_cnt != d0) break;
    end
    repeat (5) begin
      tick();
      if (rdreq) rd_after++;
    end
    vectors++;
    if (done_cnt - d0 != 1) begin
      miscompares++;
      $display("FAIL full_done got %0d exp 1", done_cnt - d0);
    end
    vectors++;
    if (beats_total - b0 != FL || reads_total - r0 != FL) begin
      miscompares++;
      $display("FAIL full_counts got beats %0d reads %0d exp %0d", beats_total - b0, reads_total - r0, FL);
    end
    vectors++;
    if (first_v - first_rd != 2) begin
      miscompares++;
      $display("FAIL full_latency got %0d exp 2", first_v - first_rd);
    end
    vectors++;
    if (busy !== 1'b1 || rd_after != 0) begin
      miscompares++;
      $display("FAIL full_back_to_fill got busy %b rdreq %0d exp 1 0", busy, rd_after);
    end
    vectors++;
    if (mon_bad != bad0) begin
      miscompares++;
      $display("FAIL full_stream got %0d violations exp 0", mon_bad - bad0);
    end
  endtask

  task automatic test_short_fill();
    int rd_seen, v_seen;
    rd_seen = 0; v_seen = 0;
    push(FL - 1);
    repeat (60) begin
      tick();
      if (rdreq) rd_seen++;
      if (sink_valid) v_seen++;
    end
    vectors++;
    if (rd_seen != 0 || v_seen != 0) begin
      miscompares++;
      $display("FAIL short_fill got rdreq %0d valid %0d exp 0 0", rd_seen, v_seen);
    end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL short_fill_busy got %b exp 1", busy);
    end
  endtask

  task automatic test_backpressure();
    int d0, b0, bad0, burst, stalls;
    d0 = done_cnt; b0 = beats_total; bad0 = mon_bad; burst = 0; stalls = 0;
    push(1);
    for (int c = 0; c < 8 * FL; c++) begin
      @(posedge CLOCK_50); #1;
      if (c < FL) begin
        sink_ready = (c % 2 == 0);
      end else if (burst > 0) begin
        sink_ready = 1'b0;
        burst--;
      end else if ($urandom_range(0, 7) == 0) begin
        sink_ready = 1'b0;
        burst = 4;
      end else begin
        sink_ready = ($urandom_range(0, 3) != 0);
      end
      if (sink_valid && !sink_ready) stalls++;
      if (done_cnt != d0) break;
    end
    sink_ready = 1'b1;
    vectors++;
    if (done_cnt - d0 != 1 || beats_total - b0 != FL) begin
      miscompares++;
      $display("FAIL bp_frame got done %0d beats %0d exp 1 %0d", done_cnt - d0, beats_total - b0, FL);
    end
    vectors++;
    if (mon_bad != bad0) begin
      miscompares++;
      $display("FAIL bp_stream got %0d violations exp 0 (stall cycles %0d)", mon_bad - bad0, stalls);
    end
  endtask

  task automatic test_underrun();
    int d0, b0, bad0, rd_forced;
    logic forced;
    d0 = done_cnt; b0 = beats_total; bad0 = mon_bad; rd_forced = 0; forced = 1'b0;
`ifdef FFT_SEQ_STATS_EN
    vectors++;
    if (underrun !== 1'b0) begin
      miscompares++;
      $display("FAIL underrun_pre got %b exp 0", underrun);
    end
`endif
    sink_ready = 1'b1;
    push(FL);
    for (int c = 0; c < 6 * FL; c++) begin
      tick();
      if (!forced && beats_total - b0 >= FL / 2) begin
        forced = 1'b1;
        force_empty = 1'b1;
        repeat (20) begin
          tick();
          if (rdreq) rd_forced++;
        end
        force_empty = 1'b0;
      end
      if (done_cnt != d0) break;
    end
    vectors++;
    if (rd_forced != 0) begin
      miscompares++;
      $display("FAIL underrun_rdreq got %0d exp 0", rd_forced);
    end
    vectors++;
    if (done_cnt - d0 != 1 || beats_total - b0 != FL || mon_bad != bad0) begin
      miscompares++;
      $display("FAIL underrun_frame got done %0d beats %0d viol %0d exp 1 %0d 0",
               done_cnt - d0, beats_total - b0, mon_bad - bad0, FL);
    end
`ifdef FFT_SEQ_STATS_EN
    vectors++;
    if (underrun !== 1'b1) begin
      miscompares++;
      $display("FAIL underrun_flag got %b exp 1", underrun);
    end
`endif
  endtask

  task automatic test_enable_drop();
    int d0, b0, r0, bad0, rd_after;
    d0 = done_cnt; b0 = beats_total; r0 = reads_total; bad0 = mon_bad; rd_after = 0;
    push(2 * FL);
    for (int c = 0; c < 6 * FL; c++) begin
      tick();
      if (beats_total - b0 >= 100) enable = 1'b0;
      if (done_cnt != d0) break;
    end
    repeat (30) begin
      tick();
      if (rdreq) rd_after++;
    end
    vectors++;
    if (done_cnt - d0 != 1 || beats_total - b0 != FL || reads_total - r0 != FL) begin
      miscompares++;
      $display("FAIL endrop_frame got done %0d beats %0d reads %0d exp 1 %0d %0d",
               done_cnt - d0, beats_total - b0, reads_total - r0, FL, FL);
    end
    vectors++;
    if (busy !== 1'b0 || rd_after != 0) begin
      miscompares++;
      $display("FAIL endrop_idle got busy %b rdreq %0d exp 0 0", busy, rd_after);
    end
    vectors++;
    if (mon_bad != bad0) begin
      miscompares++;
      $display("FAIL endrop_stream got %0d violations exp 0", mon_bad - bad0);
    end
  endtask

  task automatic test_reset_midframe();
    int b0, bad0;
    b0 = beats_total; bad0 = mon_bad;
    enable = 1'b1; sink_ready = 1'b1;
    for (int c = 0; c < 4 * FL; c++) begin
      tick();
      if (beats_total - b0 >= FL / 3) break;
    end
`ifdef FFT_SEQ_STATS_EN
    vectors++;
    if (frame_count !== 16'd4) begin
      miscompares++;
      $display("FAIL stats_count_pre got %0d exp 4", frame_count);
    end
`endif
    resetn = 1'b0;
    flush  = 1'b1;
    #1;
    vectors++;
    if ({rdreq, sink_valid, sink_sop, sink_eop, busy, frame_done} !== 6'b0 || sink_real !== 16'h0) begin
      miscompares++;
      $display("FAIL midreset_outputs got %b real %h exp 000000 0000",
               {rdreq, sink_valid, sink_sop, sink_eop, busy, frame_done}, sink_real);
    end
`ifdef FFT_SEQ_STATS_EN
    vectors++;
    if (frame_count !== 16'd0) begin
      miscompares++;
      $display("FAIL stats_count_reset got %0d exp 0", frame_count);
    end
`endif
    repeat (3) tick();
    flush  = 1'b0;
    resetn = 1'b1;
    tick();
    push(FL);
    for (int c = 0; c < 4 * FL; c++) begin
      tick();
      if (done_cnt != 0) break;
    end
    repeat (3) tick();
    vectors++;
    if (done_cnt != 1 || beats_total != FL) begin
      miscompares++;
      $display("FAIL midreset_refill got done %0d beats %0d exp 1 %0d", done_cnt, beats_total, FL);
    end
    vectors++;
    if (mon_bad != bad0) begin
      miscompares++;
      $display("FAIL midreset_stream got %0d violations exp 0", mon_bad - bad0);
    end
`ifdef FFT_SEQ_STATS_EN
    vectors++;
    if (frame_count !== 16'd1) begin
      miscompares++;
      $display("FAIL stats_count_post got %0d exp 1", frame_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_fill();
    test_backpressure();
    test_underrun();
    test_enable_drop();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
